// File: rtl/mem_arb_pkg.sv
// Shared types for the memory-port arbiter: requester ids, memory request
// payload and the in-flight read tag.
package mem_arb_pkg;

   typedef enum logic {
      OWNER_IF = 1'b0,
      OWNER_LS = 1'b1
   } owner_e;

   typedef struct packed {
      logic        we;
      logic [1:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
   } mem_req_t;

   typedef struct packed {
      logic   valid;
      owner_e owner;
   } tag_t;

   localparam logic [1:0] SIZE_BYTE = 2'd0;
   localparam logic [1:0] SIZE_HALF = 2'd1;
   localparam logic [1:0] SIZE_WORD = 2'd2;

   localparam mem_req_t MEM_REQ_IDLE = '{we: 1'b0, size: 2'd0, addr: 32'd0, wdata: 32'd0};
   localparam tag_t     TAG_EMPTY    = '{valid: 1'b0, owner: OWNER_IF};

   // Fetches are always full-word reads with no write data.
   function automatic mem_req_t fetch_req(input logic [31:0] addr);
      fetch_req = '{we: 1'b0, size: SIZE_WORD, addr: addr, wdata: 32'd0};
   endfunction

endpackage

// File: rtl/mem_arb_tag_pipe.sv
// Latency-matched shift register of read tags; the last stage lines up with
// the cycle the memory presents the corresponding read word.
module mem_arb_tag_pipe
   import mem_arb_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clk_enable,
   input  tag_t tag_in,
   output tag_t tag_out
);

   tag_t [DEPTH-1:0] stage_reg;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            stage_reg[i] <= TAG_EMPTY;
         end
      end else if (clk_enable) begin
         stage_reg[0] <= tag_in;
         for (int i = 1; i < DEPTH; i++) begin
            stage_reg[i] <= stage_reg[i-1];
         end
      end
   end

   assign tag_out = stage_reg[DEPTH-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// Fixed-priority arbiter (load/store over fetch) for the shared memory port,
// with read-response routing. Optional fetch starvation guard: MEM_ARB_STARVE_GUARD_EN.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int READ_LATENCY = 2,
   parameter int MAX_WAIT     = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clk_enable,
   input  logic        if_req_valid,
   output logic        if_req_ready,
   input  logic [31:0] if_addr,
   output logic        if_rsp_valid,
   output logic [31:0] if_rsp_data,
   input  logic        ls_req_valid,
   output logic        ls_req_ready,
   input  logic        ls_we,
   input  logic [1:0]  ls_size,
   input  logic [31:0] ls_addr,
   input  logic [31:0] ls_wdata,
   output logic        ls_rsp_valid,
   output logic [31:0] ls_rsp_data,
   output logic        mem_valid,
   output logic        mem_we,
   output logic [1:0]  mem_size,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   logic     active_reg;
   logic     live;
   logic     grant_en;
   logic     force_if;
   mem_req_t sel_req;
   tag_t     tag_in;
   tag_t     tag_out;

   // Outputs are held low through reset and for the first cycle after it.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         active_reg <= 1'b0;
      end else begin
         active_reg <= 1'b1;
      end
   end

   assign live     = rst_n && active_reg;
   assign grant_en = live && clk_enable;

`ifdef MEM_ARB_STARVE_GUARD_EN
   localparam int CW = $clog2(MAX_WAIT + 1);

   logic [CW-1:0] wait_reg;
   logic [CW-1:0] wait_next;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wait_reg <= '0;
      end else if (clk_enable) begin
         wait_reg <= wait_next;
      end
   end

   always_comb begin
      wait_next = wait_reg;
      if (!if_req_valid || if_req_ready) begin
         wait_next = '0;
      end else if (wait_reg != CW'(MAX_WAIT)) begin
         wait_next = wait_reg + 1'b1;
      end
   end

   assign force_if = (wait_reg == CW'(MAX_WAIT));
`else
   assign force_if = 1'b0;
`endif

   assign ls_req_ready = grant_en && ls_req_valid && !force_if;
   assign if_req_ready = grant_en && if_req_valid && (!ls_req_valid || force_if);

   always_comb begin
      sel_req = MEM_REQ_IDLE;
      if (ls_req_ready) begin
         sel_req = '{we: ls_we, size: ls_size, addr: ls_addr, wdata: ls_wdata};
      end else if (if_req_ready) begin
         sel_req = fetch_req(if_addr);
      end
   end

   assign mem_valid = ls_req_ready || if_req_ready;
   assign mem_we    = sel_req.we;
   assign mem_size  = sel_req.size;
   assign mem_addr  = sel_req.addr;
   assign mem_wdata = sel_req.wdata;

   // Stores enter the pipe as bubbles so they never produce a response.
   always_comb begin
      tag_in       = TAG_EMPTY;
      tag_in.valid = mem_valid && !sel_req.we;
      tag_in.owner = ls_req_ready ? OWNER_LS : OWNER_IF;
   end

   mem_arb_tag_pipe #(
      .DEPTH (READ_LATENCY)
   ) u_tag_pipe (
      .clk        (clk),
      .rst_n      (rst_n),
      .clk_enable (clk_enable),
      .tag_in     (tag_in),
      .tag_out    (tag_out)
   );

   assign if_rsp_valid = live && tag_out.valid && (tag_out.owner == OWNER_IF);
   assign ls_rsp_valid = live && tag_out.valid && (tag_out.owner == OWNER_LS);
   assign if_rsp_data  = live ? mem_rdata : 32'd0;
   assign ls_rsp_data  = live ? mem_rdata : 32'd0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a per-cycle behavioural model.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

   localparam int READ_LATENCY = 2;
   localparam int MAX_WAIT     = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        clk_enable = 1'b1;
   logic        if_req_valid = 1'b0;
   logic        if_req_ready;
   logic [31:0] if_addr = '0;
   logic        if_rsp_valid;
   logic [31:0] if_rsp_data;
   logic        ls_req_valid = 1'b0;
   logic        ls_req_ready;
   logic        ls_we = 1'b0;
   logic [1:0]  ls_size = '0;
   logic [31:0] ls_addr = '0;
   logic [31:0] ls_wdata = '0;
   logic        ls_rsp_valid;
   logic [31:0] ls_rsp_data;
   logic        mem_valid;
   logic        mem_we;
   logic [1:0]  mem_size;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata = '0;

   always #5 clk = ~clk;

   mem_port_arbiter #(
      .READ_LATENCY (READ_LATENCY),
      .MAX_WAIT     (MAX_WAIT)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .clk_enable   (clk_enable),
      .if_req_valid (if_req_valid),
      .if_req_ready (if_req_ready),
      .if_addr      (if_addr),
      .if_rsp_valid (if_rsp_valid),
      .if_rsp_data  (if_rsp_data),
      .ls_req_valid (ls_req_valid),
      .ls_req_ready (ls_req_ready),
      .ls_we        (ls_we),
      .ls_size      (ls_size),
      .ls_addr      (ls_addr),
      .ls_wdata     (ls_wdata),
      .ls_rsp_valid (ls_rsp_valid),
      .ls_rsp_data  (ls_rsp_data),
      .mem_valid    (mem_valid),
      .mem_we       (mem_we),
      .mem_size     (mem_size),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_rdata    (mem_rdata)
   );

   int checks = 0;
   int errors = 0;

   // Model state: owner of each read issued per enabled cycle since reset
   // (-1 = no read, 0 = fetch, 1 = load/store).
   int owner_log[$];
   bit after_rst = 1'b1;
   int denials = 0;
   bit acc_if = 1'b0;
   bit acc_ls = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   // mode 0: random requests, 1: both ports always requesting, 2: both idle
   task automatic run_cycle(input bit en, input bit rst, input int mode);
      bit          live;
      bit          frc;
      bit          e_ls;
      bit          e_if;
      int          owner;
      logic [31:0] e_addr;
      logic [31:0] e_wdata;
      logic [1:0]  e_size;
      bit          e_we;
      @(posedge clk);
      #1;
      rst_n      = !rst;
      clk_enable = en;
      mem_rdata  = $urandom;
      if (mode == 2) begin
         if_req_valid = 1'b0;
         ls_req_valid = 1'b0;
      end else begin
         if (!if_req_valid || acc_if) begin
            if_req_valid = (mode == 1) || ($urandom_range(0, 99) < 50);
            if_addr      = $urandom;
         end
         if (!ls_req_valid || acc_ls) begin
            ls_req_valid = (mode == 1) || ($urandom_range(0, 99) < 45);
            ls_we        = ($urandom_range(0, 2) == 0);
            ls_size      = 2'($urandom_range(0, 2));
            ls_addr      = $urandom;
            ls_wdata     = $urandom;
         end
      end
      @(negedge clk);
      live = rst_n && !after_rst;
      frc  = 1'b0;
`ifdef MEM_ARB_STARVE_GUARD_EN
      frc  = (denials >= MAX_WAIT);
`endif
      e_ls = live && clk_enable && ls_req_valid && !frc;
      e_if = live && clk_enable && if_req_valid && (!ls_req_valid || frc);
      e_we = 1'b0; e_size = 2'd0; e_addr = '0; e_wdata = '0;
      if (e_ls) begin
         e_we = ls_we; e_size = ls_size; e_addr = ls_addr; e_wdata = ls_wdata;
      end else if (e_if) begin
         e_size = 2'd2; e_addr = if_addr;
      end
      owner = -1;
      if (live && owner_log.size() >= READ_LATENCY)
         owner = owner_log[owner_log.size() - READ_LATENCY];
      check("if_req_ready", if_req_ready, e_if);
      check("ls_req_ready", ls_req_ready, e_ls);
      check("mem_valid", mem_valid, e_if || e_ls);
      check("mem_we", mem_we, e_we);
      check("mem_size", mem_size, e_size);
      check("mem_addr", mem_addr, e_addr);
      check("mem_wdata", mem_wdata, e_wdata);
      check("if_rsp_valid", if_rsp_valid, owner == 0);
      check("ls_rsp_valid", ls_rsp_valid, owner == 1);
      check("if_rsp_data", if_rsp_data, live ? mem_rdata : 32'd0);
      check("ls_rsp_data", ls_rsp_data, live ? mem_rdata : 32'd0);
      if (!rst_n) begin
         owner_log.delete();
         after_rst = 1'b1;
         denials   = 0;
      end else begin
         if (clk_enable) begin
            owner_log.push_back((e_ls && !ls_we) ? 1 : (e_if ? 0 : -1));
            if (!if_req_valid || e_if) denials = 0;
            else if (denials < MAX_WAIT) denials++;
         end
         after_rst = 1'b0;
      end
      acc_if = e_if;
      acc_ls = e_ls;
   endtask

   initial begin
      int win_grants;
      int exp_grants;
      for (int i = 0; i < 3; i++) run_cycle(1'b1, 1'b1, 0);
      for (int i = 0; i < 600; i++) run_cycle(1'b1, 1'b0, 0);
      for (int i = 0; i < 600; i++) run_cycle($urandom_range(0, 99) < 70, 1'b0, 0);
      for (int i = 0; i < 600; i++)
         run_cycle($urandom_range(0, 99) < 85, $urandom_range(0, 99) < 3, 0);
      for (int i = 0; i < 4; i++) run_cycle(1'b1, 1'b0, 0);
      // Sustained contention: with the guard, fetch wins every fifth cycle.
      run_cycle(1'b1, 1'b0, 2);
      win_grants = 0;
      for (int i = 0; i < 20; i++) begin
         run_cycle(1'b1, 1'b0, 1);
         if (if_req_ready) win_grants++;
      end
`ifdef MEM_ARB_STARVE_GUARD_EN
      exp_grants = 4;
`else
      exp_grants = 0;
`endif
      check("starve_window_if_grants", win_grants, exp_grants);
      for (int i = 0; i < 200; i++) run_cycle($urandom_range(0, 99) < 90, 1'b0, 1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single physical memory port (block-RAM bank plus MMIO window) between the instruction-fetch requester and the load/store requester.
- Grants at most one request per enabled cycle and drives the memory's address, data and control lines.
- Tracks in-flight reads in a latency-matched tag pipeline and routes each returning read word to the requester that issued it.
- Sits between the pipeline front/back ends and the memory block.

Parameters:
- READ_LATENCY, 2: enabled cycles from a granted read to valid mem_rdata (registered address plus registered output).
- MAX_WAIT, 4: enabled cycles fetch may be denied before a forced grant (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous reset, active-low.
- clk_enable  in  1  global clock enable; all state advances only when high.
- if_req_valid  in  1  fetch request.
- if_req_ready  out  1  fetch request accepted this cycle.
- if_addr  in  32  fetch byte address.
- if_rsp_valid  out  1  fetch read data valid.
- if_rsp_data  out  32  fetch read data.
- ls_req_valid  in  1  load/store request.
- ls_req_ready  out  1  load/store request accepted this cycle.
- ls_we  in  1  1 = store.
- ls_size  in  2  0 = byte, 1 = half, 2 = word.
- ls_addr  in  32  load/store byte address.
- ls_wdata  in  32  store data.
- ls_rsp_valid  out  1  load data valid.
- ls_rsp_data  out  32  load data.
- mem_valid  out  1  access issued to memory this cycle.
- mem_we  out  1  write strobe.
- mem_size  out  2  access size.
- mem_addr  out  32  address.
- mem_wdata  out  32  write data.
- mem_rdata  in  32  memory read data.

Behaviour:
- Handshake: a request transfers when valid && ready on a clk_enable cycle. Ready outputs are combinational and are 0 whenever clk_enable = 0 or rst_n = 0. A requester holds valid and payload stable until accepted.
- Grant, fixed priority: ls wins over if.
  - ls_req_ready = ls_req_valid && !force_if.
  - if_req_ready = if_req_valid && (!ls_req_valid || force_if).
  - Without the optional feature, force_if = 0.
- Memory drive: mem_valid = grant. mem_* take the payload of the granted port combinationally. Fetch grants drive mem_we = 0 and mem_size = 2.
- With mem_valid = 0, drive mem_we = 0 and mem_addr/mem_wdata = 0.
- Tag pipeline: READ_LATENCY stages of {valid, owner}, where owner 0 = if and 1 = ls.
  - On each enabled cycle the pipeline shifts.
  - Stage 0 loads valid = (grant && !mem_we) with the granted owner.
  - Stores enter as invalid and never produce a response.
- Response: the last stage routes mem_rdata.
  - if_rsp_valid = last.valid && owner == 0; ls_rsp_valid = last.valid && owner == 1.
  - Both rsp_data outputs carry mem_rdata unconditionally.
  - Responses return in issue order; no backpressure on responses.
- clk_enable = 0: pipeline, counter and all state hold; no grants; rsp_valid outputs hold their current value.
- Throughput: one access per enabled cycle. Back-to-back reads from alternating owners are legal and are routed correctly.
- Reset: all tag stages invalid and wait counter = 0.
  - Every output is 0 during reset and in the first cycle after it.
  - Reads in flight at reset are discarded; their data is never delivered.
- Simultaneous valid on both ports: exactly one ready is high.

Optional Feature:
- Macro: MEM_ARB_STARVE_GUARD_EN.
- Defined:
  - A counter of width $clog2(MAX_WAIT+1) increments on each enabled cycle where if_req_valid && !if_req_ready, saturating at MAX_WAIT.
  - force_if = (count == MAX_WAIT).
  - The counter clears on fetch grant, or when if_req_valid is low.
- Undefined: no counter exists; pure fixed priority applies and fetch may starve indefinitely.

Decomposition:
- Package mem_arb_pkg holds:
  - typedef owner_e {OWNER_IF, OWNER_LS};
  - struct mem_req_t {we, size, addr, wdata};
  - struct tag_t {valid, owner}.
- One sub-module, mem_arb_tag_pipe: the READ_LATENCY-deep tag shift register with clk_enable and reset. Grant logic stays in the top.

Test Plan:
- Single fetch read of 0x00000010 at cycle 5, memory returns 0xDEADBEEF: if_req_ready high at cycle 5; if_rsp_valid high exactly at cycle 7 with data 0xDEADBEEF; ls_rsp_valid stays 0.
- Both ports valid at cycle 3 (ls load 0x20, if 0x40): ls granted at cycle 3 and if at cycle 4; mem_addr is 0x20 then 0x40; ls_rsp at cycle 5 and if_rsp at cycle 6.
- ls store (size 0, wdata 0xAB, addr 0x101) back-to-back with ls load: mem_we pulses one cycle; no response for the store; the load response arrives 2 cycles after its grant.
- clk_enable low for 3 cycles while a read is in flight: no ready asserted; rsp_valid delayed by exactly 3 cycles; data is still routed to the correct owner.
- rst_n low one cycle after a fetch grant: no if_rsp_valid ever appears for that request; all outputs 0 during reset.
- With MEM_ARB_STARVE_GUARD_EN and continuous ls_req_valid plus if_req_valid: fetch is granted on the 5th cycle (after 4 denials), then ls resumes. Without the macro, fetch is never granted.
